// File: rtl/digit_scan_ctrl.sv
// Digit scan sequencer driving a 3-to-8 decoder: SHOW each digit for DWELL clocks, then BLANK dead clocks.
// Optional digit skipping is enabled by defining SCAN_MASK_EN (adds the iMask port).
module digit_scan_ctrl #(
    parameter int DWELL      = 100000,
    parameter int BLANK      = 4,
    parameter int LAST_DIGIT = 7
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRun,
    output logic [2:0] oData,
    output logic [1:0] oEna,
    output logic       oStrobe,
    output logic       oWrap
`ifdef SCAN_MASK_EN
    ,
    input  logic [7:0] iMask
`endif
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
    localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DWELL - 1);
    localparam logic [BW-1:0] BCNT_LAST = (BLANK > 0) ? BW'(BLANK - 1) : {BW{1'b0}};
    localparam logic [2:0]    LAST      = 3'(LAST_DIGIT);
    localparam logic [1:0]    ENA_ON    = 2'b10;
    localparam logic [1:0]    ENA_OFF   = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t          r_state;
    logic [2:0]      r_data;
    logic [1:0]      r_ena;
    logic            r_strobe;
    logic            r_wrap;
    logic [DW-1:0]   r_dcnt;
    logic [BW-1:0]   r_bcnt;
    logic            r_hold;

    state_t          w_state_nx;
    logic [2:0]      w_data_nx;
    logic [1:0]      w_ena_nx;
    logic            w_strobe_nx;
    logic            w_wrap_nx;
    logic [DW-1:0]   w_dcnt_nx;
    logic [BW-1:0]   w_bcnt_nx;
    logic            w_hold_nx;

    // {found, index} candidates for the start digit and for the next digit
    logic [3:0]      w_first;
    logic [3:0]      w_next;

`ifdef SCAN_MASK_EN
    function automatic logic [3:0] lowest_unmasked(input logic [7:0] mask);
        logic [3:0] res;
        res = 4'b0000;
        for (int k = LAST_DIGIT; k >= 0; k--) begin
            if (!mask[k]) begin
                res = {1'b1, 3'(k)};
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] next_unmasked(input logic [2:0] old, input logic [7:0] mask);
        logic [2:0] cand;
        logic [3:0] res;
        cand = old;
        res  = 4'b0000;
        for (int k = 0; k <= LAST_DIGIT; k++) begin
            cand = (cand == LAST) ? 3'd0 : cand + 3'd1;
            if (!res[3] && !mask[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    // Recovering from an all-masked hold restarts at the lowest digit, otherwise step cyclically
    always_comb begin
        w_first = lowest_unmasked(iMask);
        if (r_hold) begin
            w_next = w_first;
        end else begin
            w_next = next_unmasked(r_data, iMask);
        end
    end
`else
    // Without masking every digit is eligible
    always_comb begin
        w_first = 4'b1000;
        if (r_data == LAST) begin
            w_next = 4'b1000;
        end else begin
            w_next = {1'b1, r_data + 3'd1};
        end
    end
`endif

    // State register and registered outputs
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state  <= S_IDLE;
            r_data   <= 3'd0;
            r_ena    <= ENA_OFF;
            r_strobe <= 1'b0;
            r_wrap   <= 1'b0;
            r_dcnt   <= {DW{1'b0}};
            r_bcnt   <= {BW{1'b0}};
            r_hold   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_data   <= w_data_nx;
            r_ena    <= w_ena_nx;
            r_strobe <= w_strobe_nx;
            r_wrap   <= w_wrap_nx;
            r_dcnt   <= w_dcnt_nx;
            r_bcnt   <= w_bcnt_nx;
            r_hold   <= w_hold_nx;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nx  = r_state;
        w_data_nx   = r_data;
        w_ena_nx    = r_ena;
        w_strobe_nx = 1'b0;
        w_wrap_nx   = 1'b0;
        w_dcnt_nx   = r_dcnt;
        w_bcnt_nx   = r_bcnt;
        w_hold_nx   = r_hold;
        case (r_state)
            S_IDLE: begin
                w_data_nx = 3'd0;
                w_ena_nx  = ENA_OFF;
                w_dcnt_nx = {DW{1'b0}};
                w_bcnt_nx = {BW{1'b0}};
                w_hold_nx = 1'b0;
                if (iRun) begin
                    if (w_first[3]) begin
                        w_state_nx  = S_SHOW;
                        w_data_nx   = w_first[2:0];
                        w_ena_nx    = ENA_ON;
                        w_strobe_nx = 1'b1;
                    end else begin
                        w_state_nx = S_BLANK;
                        w_hold_nx  = 1'b1;
                    end
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_SHOW, S_BLANK: begin
                if (!iRun) begin
                    w_state_nx = S_IDLE;
                    w_data_nx  = 3'd0;
                    w_ena_nx   = ENA_OFF;
                    w_dcnt_nx  = {DW{1'b0}};
                    w_bcnt_nx  = {BW{1'b0}};
                    w_hold_nx  = 1'b0;
                end else if (r_state == S_SHOW && r_dcnt != DCNT_LAST) begin
                    w_dcnt_nx = r_dcnt + {{(DW-1){1'b0}}, 1'b1};
                end else if (r_state == S_SHOW && BLANK > 0) begin
                    w_state_nx = S_BLANK;
                    w_ena_nx   = ENA_OFF;
                    w_dcnt_nx  = {DW{1'b0}};
                    w_bcnt_nx  = {BW{1'b0}};
                end else if (r_state == S_BLANK && !r_hold && r_bcnt != BCNT_LAST) begin
                    w_bcnt_nx = r_bcnt + {{(BW-1){1'b0}}, 1'b1};
                end else if (w_next[3]) begin
                    // Advance: end of dwell with no blank phase, end of blank, or a mask cleared
                    w_state_nx  = S_SHOW;
                    w_data_nx   = w_next[2:0];
                    w_ena_nx    = ENA_ON;
                    w_strobe_nx = 1'b1;
                    w_wrap_nx   = (w_next[2:0] <= r_data);
                    w_dcnt_nx   = {DW{1'b0}};
                    w_bcnt_nx   = {BW{1'b0}};
                    w_hold_nx   = 1'b0;
                end else begin
                    w_state_nx = S_BLANK;
                    w_ena_nx   = ENA_OFF;
                    w_dcnt_nx  = {DW{1'b0}};
                    w_bcnt_nx  = {BW{1'b0}};
                    w_hold_nx  = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_data_nx  = 3'd0;
                w_ena_nx   = ENA_OFF;
                w_dcnt_nx  = {DW{1'b0}};
                w_bcnt_nx  = {BW{1'b0}};
                w_hold_nx  = 1'b0;
            end
        endcase
    end

    assign oData   = r_data;
    assign oEna    = r_ena;
    assign oStrobe = r_strobe;
    assign oWrap   = r_wrap;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: DWELL=4, BLANK=2, LAST_DIGIT=2, plus a BLANK=0 instance.
module tb_digit_scan_ctrl;

    logic       iClk;
    logic       iRst;
    logic       run_a;
    logic       run_b;
    logic [2:0] data_a;
    logic [1:0] ena_a;
    logic       strobe_a;
    logic       wrap_a;
    logic [2:0] data_b;
    logic [1:0] ena_b;
    logic       strobe_b;
    logic       wrap_b;
`ifdef SCAN_MASK_EN
    logic [7:0] mask_a;
    logic [7:0] mask_b;
`endif

    int n_total;
    int n_pass;

    digit_scan_ctrl #(.DWELL(4), .BLANK(2), .LAST_DIGIT(2)) u_dut (
        .iClk(iClk), .iRst(iRst), .iRun(run_a),
        .oData(data_a), .oEna(ena_a), .oStrobe(strobe_a), .oWrap(wrap_a)
`ifdef SCAN_MASK_EN
        , .iMask(mask_a)
`endif
    );

    digit_scan_ctrl #(.DWELL(4), .BLANK(0), .LAST_DIGIT(2)) u_dut_b0 (
        .iClk(iClk), .iRst(iRst), .iRun(run_b),
        .oData(data_b), .oEna(ena_b), .oStrobe(strobe_b), .oWrap(wrap_b)
`ifdef SCAN_MASK_EN
        , .iMask(mask_b)
`endif
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic test_reset_idle;
        n_total++;
        if ({ena_a, data_a, strobe_a, wrap_a} !== 7'b00_000_0_0)
            $display("FAIL reset_state: got ena=%b data=%b strobe=%b wrap=%b, want 00 000 0 0", ena_a, data_a, strobe_a, wrap_a);
        else n_pass++;
        iRst = 1'b0;
        tick(2);
        run_a = 1'b1; #2; run_a = 1'b0;
        tick(2);
        n_total++;
        if ({ena_a, data_a, strobe_a} !== 6'b00_000_0)
            $display("FAIL idle_hold: got ena=%b data=%b strobe=%b, want 00 000 0", ena_a, data_a, strobe_a);
        else n_pass++;
    endtask

    task automatic test_start;
        run_a = 1'b1;
        tick(1);
        n_total++;
        if ({ena_a, data_a, strobe_a, wrap_a} !== 7'b10_000_1_0)
            $display("FAIL start_entry: got ena=%b data=%b strobe=%b wrap=%b, want 10 000 1 0", ena_a, data_a, strobe_a, wrap_a);
        else n_pass++;
        for (int i = 1; i < 4; i++) begin
            tick(1);
            n_total++;
            if ({ena_a, data_a, strobe_a} !== 6'b10_000_0)
                $display("FAIL start_dwell%0d: got ena=%b data=%b strobe=%b, want 10 000 0", i, ena_a, data_a, strobe_a);
            else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            tick(1);
            n_total++;
            if ({ena_a, data_a, strobe_a} !== 6'b00_000_0)
                $display("FAIL start_blank%0d: got ena=%b data=%b strobe=%b, want 00 000 0", i, ena_a, data_a, strobe_a);
            else n_pass++;
        end
        tick(1);
        n_total++;
        if ({ena_a, data_a, strobe_a, wrap_a} !== 7'b10_001_1_0)
            $display("FAIL start_digit1: got ena=%b data=%b strobe=%b wrap=%b, want 10 001 1 0", ena_a, data_a, strobe_a, wrap_a);
        else n_pass++;
    endtask

    task automatic test_wrap;
        int cnt;
        tick(6);
        n_total++;
        if ({ena_a, data_a, strobe_a, wrap_a} !== 7'b10_010_1_0)
            $display("FAIL wrap_digit2: got ena=%b data=%b strobe=%b wrap=%b, want 10 010 1 0", ena_a, data_a, strobe_a, wrap_a);
        else n_pass++;
        tick(6);
        n_total++;
        if ({ena_a, data_a, strobe_a, wrap_a} !== 7'b10_000_1_1)
            $display("FAIL wrap_return: got ena=%b data=%b strobe=%b wrap=%b, want 10 000 1 1", ena_a, data_a, strobe_a, wrap_a);
        else n_pass++;
        cnt = 0;
        do begin
            tick(1);
            cnt++;
        end while (!(strobe_a === 1'b1 && data_a === 3'd0) && cnt < 40);
        n_total++;
        if (cnt !== 18)
            $display("FAIL wrap_period: got %0d clocks, want 18", cnt);
        else n_pass++;
    endtask

    task automatic test_stop;
        tick(6);
        tick(1);
        n_total++;
        if ({ena_a, data_a, strobe_a} !== 6'b10_001_0)
            $display("FAIL stop_pre: got ena=%b data=%b strobe=%b, want 10 001 0", ena_a, data_a, strobe_a);
        else n_pass++;
        run_a = 1'b0;
        tick(1);
        n_total++;
        if ({ena_a, data_a, strobe_a} !== 6'b00_000_0)
            $display("FAIL stop_idle: got ena=%b data=%b strobe=%b, want 00 000 0", ena_a, data_a, strobe_a);
        else n_pass++;
        tick(3);
        run_a = 1'b1;
        tick(1);
        n_total++;
        if ({ena_a, data_a, strobe_a, wrap_a} !== 7'b10_000_1_0)
            $display("FAIL stop_restart: got ena=%b data=%b strobe=%b wrap=%b, want 10 000 1 0", ena_a, data_a, strobe_a, wrap_a);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        tick(1);
        iRst = 1'b1;
        #2;
        n_total++;
        if ({ena_a, data_a, strobe_a} !== 6'b00_000_0)
            $display("FAIL reset_async: got ena=%b data=%b strobe=%b, want 00 000 0", ena_a, data_a, strobe_a);
        else n_pass++;
        tick(2);
        n_total++;
        if ({ena_a, strobe_a} !== 3'b00_0)
            $display("FAIL reset_wins: got ena=%b strobe=%b, want 00 0", ena_a, strobe_a);
        else n_pass++;
        run_a = 1'b0;
        iRst  = 1'b0;
        tick(3);
        n_total++;
        if ({ena_a, data_a, strobe_a} !== 6'b00_000_0)
            $display("FAIL reset_release: got ena=%b data=%b strobe=%b, want 00 000 0", ena_a, data_a, strobe_a);
        else n_pass++;
    endtask

    task automatic test_blank0;
        logic [2:0] exp_d;
        run_b = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick(1);
            exp_d = 3'((k / 4) % 3);
            n_total++;
            if (ena_b !== 2'b10 || data_b !== exp_d || strobe_b !== (k % 4 == 0))
                $display("FAIL blank0_k%0d: got ena=%b data=%b strobe=%b, want 10 %b %b", k, ena_b, data_b, strobe_b, exp_d, (k % 4 == 0));
            else n_pass++;
        end
        n_total++;
        if (wrap_b !== 1'b1)
            $display("FAIL blank0_wrap: got %b, want 1", wrap_b);
        else n_pass++;
        run_b = 1'b0;
    endtask

`ifdef SCAN_MASK_EN
    task automatic test_mask;
        mask_a = 8'h02;
        run_a  = 1'b1;
        tick(1);
        n_total++;
        if ({ena_a, data_a, strobe_a} !== 6'b10_000_1)
            $display("FAIL mask_start: got ena=%b data=%b strobe=%b, want 10 000 1", ena_a, data_a, strobe_a);
        else n_pass++;
        tick(6);
        n_total++;
        if ({ena_a, data_a, strobe_a, wrap_a} !== 7'b10_010_1_0)
            $display("FAIL mask_skip: got ena=%b data=%b strobe=%b wrap=%b, want 10 010 1 0", ena_a, data_a, strobe_a, wrap_a);
        else n_pass++;
        tick(6);
        n_total++;
        if ({ena_a, data_a, strobe_a, wrap_a} !== 7'b10_000_1_1)
            $display("FAIL mask_wrap: got ena=%b data=%b strobe=%b wrap=%b, want 10 000 1 1", ena_a, data_a, strobe_a, wrap_a);
        else n_pass++;
        mask_a = 8'h07;
        tick(9);
        n_total++;
        if ({ena_a, strobe_a} !== 3'b00_0)
            $display("FAIL mask_all: got ena=%b strobe=%b, want 00 0", ena_a, strobe_a);
        else n_pass++;
        mask_a = 8'h03;
        tick(1);
        n_total++;
        if ({ena_a, data_a, strobe_a} !== 6'b10_010_1)
            $display("FAIL mask_resume: got ena=%b data=%b strobe=%b, want 10 010 1", ena_a, data_a, strobe_a);
        else n_pass++;
        run_a = 1'b0;
        tick(1);
    endtask
`endif

    initial begin
        n_total = 0;
        n_pass  = 0;
        iRst    = 1'b1;
        run_a   = 1'b0;
        run_b   = 1'b0;
`ifdef SCAN_MASK_EN
        mask_a  = 8'h00;
        mask_b  = 8'h00;
`endif
        tick(2);
        test_reset_idle;
        test_start;
        test_wrap;
        test_stop;
        test_async_reset;
        test_blank0;
`ifdef SCAN_MASK_EN
        test_mask;
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
